// File: rtl/vram_pkg.sv
// Shared constants and types for the multi-plane VRAM controller.
// Default I/O port map, plane limit and clear-engine state encoding.
package vram_pkg;

    localparam int MAX_PLANES = 8;

    localparam logic [7:0] IO_RD_BANK_DEF = 8'hF1;
    localparam logic [7:0] IO_WR_BANK_DEF = 8'hF2;
    localparam logic [7:0] IO_CLEAR_DEF   = 8'hF3;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

endpackage

// File: rtl/vram_plane.sv
// One byte-wide VRAM plane: port A read/write for CPU and clear engine,
// port B read-only for scanout. Both ports have registered read data.
module vram_plane #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic          a_re,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_din,
    output logic [7:0]    a_dout,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_dout
);

    logic [7:0] mem [2**AW];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (a_re) begin
            a_rdata_q <= mem[a_addr];
        end
        b_rdata_q <= mem[b_addr];
    end

    assign a_dout = a_rdata_q;
    assign b_dout = b_rdata_q;

endmodule

// File: rtl/vram_plane_ctrl.sv
// Multi-plane VRAM controller with bank/mask registers and scanout port.
// Optional hardware clear engine is built when VRAM_CLEAR_EN is defined.
module vram_plane_ctrl
    import vram_pkg::*;
#(
    parameter int         PLANES     = 6,
    parameter int         AW         = 13,
    parameter logic [7:0] IO_RD_BANK = IO_RD_BANK_DEF,
    parameter logic [7:0] IO_WR_BANK = IO_WR_BANK_DEF,
    parameter logic [7:0] IO_CLEAR   = IO_CLEAR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_wr,
    input  logic [7:0]            io_addr,
    input  logic [7:0]            io_din,
    input  logic                  mem_en,
    input  logic                  mem_wr,
    input  logic [AW-1:0]         addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  cpu_wait,
    input  logic [AW-1:0]         vaddr,
    output logic [PLANES*8-1:0]   vdata,
    output logic                  busy
);

    localparam int NP = (PLANES < MAX_PLANES) ? PLANES : MAX_PLANES;

    logic [7:0]    rd_bank_q, rd_bank_d;
    logic [NP-1:0] wr_mask_q, wr_mask_d;
    logic [7:0]    rd_sel_q, rd_sel_d;

    logic          busy_w;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] a_addr;
    logic [7:0]    a_din;
    logic [NP-1:0] a_we;
    logic [7:0]    a_dout [NP];

    always_comb begin
        rd_bank_d = rd_bank_q;
        wr_mask_d = wr_mask_q;
        if (io_wr && io_addr == IO_RD_BANK) begin
            rd_bank_d = io_din;
        end
        if (io_wr && io_addr == IO_WR_BANK) begin
            wr_mask_d = io_din[NP-1:0];
        end
        cpu_wait = mem_en & busy_w;
        cpu_rd   = mem_en & ~mem_wr & ~cpu_wait;
        cpu_wr   = mem_en & mem_wr & ~cpu_wait;
        // bank captured with the read so a later bank write cannot alter dout
        rd_sel_d = cpu_rd ? rd_bank_q : rd_sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank_q <= '0;
            wr_mask_q <= '0;
            rd_sel_q  <= '0;
        end else begin
            rd_bank_q <= rd_bank_d;
            wr_mask_q <= wr_mask_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

`ifdef VRAM_CLEAR_EN
    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    fill_q, fill_d;
    logic [NP-1:0] cmask_q, cmask_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        cmask_d = cmask_q;
        unique case (state_q)
            IDLE: begin
            end
            CLEAR: begin
                cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a new trigger always restarts, even mid-clear
        if (io_wr && io_addr == IO_CLEAR) begin
            state_d = CLEAR;
            cnt_d   = '0;
            fill_d  = io_din;
            cmask_d = wr_mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            cmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            cmask_q <= cmask_d;
        end
    end

    assign busy_w = (state_q == CLEAR);

    always_comb begin
        a_addr = addr;
        a_din  = din;
        a_we   = cpu_wr ? wr_mask_q : '0;
        if (busy_w) begin
            a_addr = cnt_q;
            a_din  = fill_q;
            a_we   = cmask_q;
        end
    end
`else
    assign busy_w = 1'b0;

    always_comb begin
        a_addr = addr;
        a_din  = din;
        a_we   = cpu_wr ? wr_mask_q : '0;
    end
`endif

    assign busy = busy_w;

    for (genvar i = 0; i < NP; i++) begin : g_plane
        vram_plane #(
            .AW(AW)
        ) u_plane (
            .clk    (clk),
            .a_we   (a_we[i]),
            .a_re   (cpu_rd),
            .a_addr (a_addr),
            .a_din  (a_din),
            .a_dout (a_dout[i]),
            .b_addr (vaddr),
            .b_dout (vdata[8*i +: 8])
        );
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < NP; i++) begin
            if (rd_sel_q == 8'(i + 1)) begin
                dout = a_dout[i];
            end
        end
    end

endmodule

// File: tb/tb_vram_plane_ctrl.sv
// Scoreboard bench for vram_plane_ctrl: CPU reads and scanout lanes
// are queued as expectations and checked by a separate monitor.
module tb_vram_plane_ctrl;

    localparam int PLANES = 6;
    localparam int AW     = 13;
    localparam int DEPTH  = 2**AW;
    localparam int LIMIT  = 10000;

    logic                clk;
    logic                reset;
    logic                io_wr;
    logic [7:0]          io_addr;
    logic [7:0]          io_din;
    logic                mem_en;
    logic                mem_wr;
    logic [AW-1:0]       addr;
    logic [7:0]          din;
    logic [7:0]          dout;
    logic                cpu_wait;
    logic [AW-1:0]       vaddr;
    logic [PLANES*8-1:0] vdata;
    logic                busy;

    vram_plane_ctrl #(
        .PLANES(PLANES),
        .AW(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_din   (io_din),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .cpu_wait (cpu_wait),
        .vaddr    (vaddr),
        .vdata    (vdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    typedef struct {
        string               name;
        logic [PLANES*8-1:0] exp;
    } vd_exp_t;

    rd_exp_t rd_q[$];
    vd_exp_t vd_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   busy_cycles = 0;
    logic rd_seen  = 1'b0;
    logic vd_req   = 1'b0;
    logic vd_seen  = 1'b0;

    always @(posedge clk) begin
        rd_seen <= mem_en && !mem_wr && !cpu_wait && !reset;
        vd_seen <= vd_req;
    end

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
    end

    always @(negedge clk) begin
        rd_exp_t re;
        vd_exp_t ve;
        if (rd_seen) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual=%h required=none", dout);
            end else begin
                re = rd_q.pop_front();
                if (dout !== re.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", re.name, dout, re.exp);
                end
            end
        end
        if (vd_seen) begin
            checks++;
            if (vd_q.size() == 0) begin
                failures++;
                $display("FAIL vd_unexpected actual=%h required=none", vdata);
            end else begin
                ve = vd_q.pop_front();
                if (vdata !== ve.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", ve.name, vdata, ve.exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [PLANES*8-1:0] lanes(input logic [7:0] m,
                                                  input logic [7:0] on,
                                                  input logic [7:0] off);
        logic [PLANES*8-1:0] v;
        for (int i = 0; i < PLANES; i++) v[8*i +: 8] = m[i] ? on : off;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1'b1; io_addr = a; io_din = d;
        tick();
        io_wr = 1'b0;
    endtask

    task automatic cpu_access(input logic wr, input logic [AW-1:0] a,
                              input logic [7:0] d, output int waited);
        mem_en = 1'b1; mem_wr = wr; addr = a; din = d;
        #0;
        waited = 0;
        while (cpu_wait === 1'b1 && waited < LIMIT) begin
            tick();
            waited++;
        end
        if (waited >= LIMIT) begin
            checks++; failures++;
            $display("FAIL cpu_wait_timeout actual=%0d required<%0d", waited, LIMIT);
        end
        tick();
        mem_en = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        int w;
        cpu_access(1'b1, a, d, w);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] exp,
                            input string name, output int waited);
        rd_q.push_back('{name, exp});
        cpu_access(1'b0, a, 8'h00, waited);
    endtask

    task automatic scan(input logic [AW-1:0] a, input logic [PLANES*8-1:0] exp,
                        input string name);
        vaddr = a;
        vd_q.push_back('{name, exp});
        vd_req = 1'b1;
        tick();
        vd_req = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            checks++; failures++;
            $display("FAIL busy_timeout actual=%0d required<%0d", n, LIMIT);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

`ifdef VRAM_CLEAR_EN
    localparam logic [7:0] V10 = 8'h55;
`else
    localparam logic [7:0] V10 = 8'hA5;
`endif

    initial begin
        int w;
        int n;
        int b0;

        reset = 1'b1; io_wr = 1'b0; io_addr = '0; io_din = '0;
        mem_en = 1'b0; mem_wr = 1'b0; addr = '0; din = '0; vaddr = '0;
        repeat (3) tick();
        check("rst_dout", 64'(dout), 64'h00);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_cpu_wait", 64'(cpu_wait), 64'h0);
        reset = 1'b0;
        tick();

        io_write(8'hF2, 8'h3F);
`ifdef VRAM_CLEAR_EN
        b0 = busy_cycles;
        io_write(8'hF3, 8'h00);
        wait_idle(n);
        check("init_clear_len", 64'(busy_cycles - b0), 64'(DEPTH));
`else
        cpu_write(13'h0010, 8'h00);
        cpu_write(13'h0020, 8'h00);
`endif
        scan(13'h0010, lanes(8'h00, 8'h00, 8'h00), "init_scan_10");

        io_write(8'hF2, 8'h05);
        cpu_write(13'h0010, 8'hA5);
        io_write(8'hF1, 8'h01);
        cpu_read(13'h0010, 8'hA5, "rd_bank1", w);
        io_write(8'hF1, 8'h02);
        cpu_read(13'h0010, 8'h00, "rd_bank2", w);
        io_write(8'hF1, 8'h03);
        cpu_read(13'h0010, 8'hA5, "rd_bank3", w);
        scan(13'h0010, lanes(8'h05, 8'hA5, 8'h00), "scan_mask05");

        io_write(8'hF1, 8'h07);
        cpu_read(13'h0010, 8'h00, "rd_bank7", w);
        io_write(8'hF1, 8'h00);
        cpu_read(13'h0010, 8'h00, "rd_bank0", w);
        io_write(8'hF1, 8'h06);
        cpu_read(13'h0010, 8'h00, "rd_bank6", w);

        io_write(8'hF1, 8'h01);
        cpu_read(13'h0010, 8'hA5, "rd_before_hold", w);
        repeat (3) tick();
        check("dout_hold", 64'(dout), 64'hA5);

        io_wr = 1'b1; io_addr = 8'hF1; io_din = 8'h00;
        mem_en = 1'b1; mem_wr = 1'b0; addr = 13'h0010;
        rd_q.push_back('{"rd_same_cycle_old_bank", 8'hA5});
        tick();
        io_wr = 1'b0; mem_en = 1'b0;
        cpu_read(13'h0010, 8'h00, "rd_after_bank_write", w);

        io_wr = 1'b1; io_addr = 8'hF2; io_din = 8'h02;
        mem_en = 1'b1; mem_wr = 1'b1; addr = 13'h0020; din = 8'h5A;
        tick();
        io_wr = 1'b0; mem_en = 1'b0; mem_wr = 1'b0;
        scan(13'h0020, lanes(8'h05, 8'h5A, 8'h00), "wr_same_cycle_old_mask");
        cpu_write(13'h0020, 8'h77);
        scan(13'h0020, lanes(8'h05, 8'h5A, 8'h00) | lanes(8'h02, 8'h77, 8'h00),
             "wr_new_mask");

        io_write(8'hF2, 8'hC0);
        cpu_write(13'h0020, 8'hFF);
        io_write(8'hF2, 8'h00);
        cpu_write(13'h0020, 8'hEE);
        scan(13'h0020, lanes(8'h05, 8'h5A, 8'h00) | lanes(8'h02, 8'h77, 8'h00),
             "wr_mask_ignored");

`ifdef VRAM_CLEAR_EN
        io_write(8'hF2, 8'h3F);
        io_write(8'hF1, 8'h01);
        b0 = busy_cycles;
        io_write(8'hF3, 8'h3C);
        check("clr_busy_rise", 64'(busy), 64'h1);
        repeat (20) tick();
        io_write(8'hF2, 8'h01);
        repeat (20) tick();
        mem_en = 1'b1; mem_wr = 1'b0; addr = 13'h0010;
        #1;
        check("clr_cpu_wait", 64'(cpu_wait), 64'h1);
        cpu_read(13'h0010, 8'h3C, "rd_after_clear", w);
        check("clr_read_stalled", 64'(w > 0), 64'h1);
        check("clr_len_8192", 64'(busy_cycles - b0), 64'(DEPTH));
        check("clr_busy_fall", 64'(busy), 64'h0);
        scan(13'h0000, lanes(8'hFF, 8'h3C, 8'h3C), "clr_scan_0");
        scan(13'h1FFF, lanes(8'hFF, 8'h3C, 8'h3C), "clr_scan_1fff");

        io_write(8'hF2, 8'h3F);
        b0 = busy_cycles;
        io_write(8'hF3, 8'h11);
        repeat (99) tick();
        io_write(8'hF3, 8'h22);
        wait_idle(n);
        check("restart_len", 64'(busy_cycles - b0), 64'(DEPTH + 100));
        scan(13'h0000, lanes(8'hFF, 8'h22, 8'h22), "restart_scan_0");
        scan(13'h1FFF, lanes(8'hFF, 8'h22, 8'h22), "restart_scan_1fff");

        io_write(8'hF3, 8'h55);
        repeat (49) tick();
        reset = 1'b1; mem_en = 1'b1; mem_wr = 1'b0; addr = 13'h0000;
        tick();
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_cpu_wait", 64'(cpu_wait), 64'h0);
        mem_en = 1'b0;
        reset = 1'b0;
        tick();
        cpu_read(13'h0000, 8'h00, "abort_rd_bank0", w);
        cpu_write(13'h0000, 8'h77);
        scan(13'h0000, lanes(8'hFF, 8'h55, 8'h55), "abort_mask0");
`else
        io_write(8'hF2, 8'h3F);
        io_write(8'hF3, 8'h3C);
        check("noclr_busy_a", 64'(busy), 64'h0);
        tick();
        check("noclr_busy_b", 64'(busy), 64'h0);
        mem_en = 1'b1; mem_wr = 1'b0; addr = 13'h0010;
        #1;
        check("noclr_cpu_wait", 64'(cpu_wait), 64'h0);
        mem_en = 1'b0;
        tick();
        scan(13'h0010, lanes(8'h05, 8'hA5, 8'h00), "noclr_mem_kept");
`endif

        io_write(8'hF1, 8'h01);
        io_write(8'hF2, 8'h3F);
        cpu_read(13'h0010, V10, "pre_reset_rd", w);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("reset_dout", 64'(dout), 64'h00);
        cpu_read(13'h0010, 8'h00, "reset_rd_bank0", w);
        cpu_write(13'h0010, 8'h99);
        io_write(8'hF1, 8'h01);
        cpu_read(13'h0010, V10, "reset_mask0", w);

        repeat (3) tick();
        check("rd_q_drained", 64'(rd_q.size()), 64'h0);
        check("vd_q_drained", 64'(vd_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
